// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - FIFO of evicted dirty lines with associative refill lookup.
// Optional in-place merge of repeated evictions: define WB_BUFFER_MERGE_EN.
module writeback_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64,
   parameter int CHUNKS_LOG = 4,
   parameter int DEPTH      = 4,
   parameter int LINE_W     = DATA_WIDTH * (2 ** CHUNKS_LOG)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  evict_valid,
   output logic                  evict_ready,
   input  logic [ADDR_WIDTH-1:0] evict_addr,
   input  logic [LINE_W-1:0]     evict_data,
   output logic                  command_valid,
   output logic                  command_store,
   output logic                  command_rready,
   output logic [ADDR_WIDTH-1:0] command_addr,
   output logic [LINE_W-1:0]     data_in,
   input  logic                  bus_ready,
   input  logic [ADDR_WIDTH-1:0] lookup_addr,
   output logic                  lookup_hit,
   output logic [LINE_W-1:0]     lookup_data,
   output logic                  empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OFS   = CHUNKS_LOG + $clog2(DATA_WIDTH / 8);
   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
   logic [LINE_W-1:0]     entry_data [DEPTH];
   logic [DEPTH-1:0]      valid;
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [PTR_W:0]        count;

   logic push;
   logic pop;
   logic alloc;
   logic merge_hit;
   logic [PTR_W-1:0] merge_idx;

   logic unused_bits;
   assign unused_bits = ^{lookup_addr[OFS-1:0]};

   function automatic logic same_line(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
      return a[ADDR_WIDTH-1:OFS] == b[ADDR_WIDTH-1:OFS];
   endfunction

   assign empty          = (count == '0);
   assign evict_ready    = (count != FULL);
   assign command_valid  = !empty;
   assign command_store  = !empty;
   assign command_rready = 1'b0;
   assign command_addr   = empty ? '0 : entry_addr[head];
   assign data_in        = empty ? '0 : entry_data[head];

   assign push = evict_valid && evict_ready;
   assign pop  = command_valid && bus_ready;

`ifdef WB_BUFFER_MERGE_EN
   // The head is excluded because the arbiter may already be moving it.
   always_comb begin
      merge_hit = 1'b0;
      merge_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && (PTR_W'(i) != head) && same_line(entry_addr[i], evict_addr)) begin
            merge_hit = 1'b1;
            merge_idx = PTR_W'(i);
         end
      end
   end
`else
   assign merge_hit = 1'b0;
   assign merge_idx = '0;
`endif

   assign alloc = push && !merge_hit;

   // Scan oldest to youngest so the youngest matching line wins.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (valid[head + PTR_W'(k)] && same_line(entry_addr[head + PTR_W'(k)], lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = entry_data[head + PTR_W'(k)];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (pop) begin
            head        <= head + PTR_W'(1);
            valid[head] <= 1'b0;
         end
         if (alloc) begin
            tail        <= tail + PTR_W'(1);
            valid[tail] <= 1'b1;
         end
         case ({alloc, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset: it is only observed through valid/count.
   always_ff @(posedge clk) begin
      if (alloc) begin
         entry_addr[tail] <= evict_addr;
         entry_data[tail] <= evict_data;
      end else if (push && merge_hit) begin
         entry_addr[merge_idx] <= evict_addr;
         entry_data[merge_idx] <= evict_data;
      end
   end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - directed self-checking bench for writeback_buffer.
// Expectations for the last scenario follow WB_BUFFER_MERGE_EN when it is defined.
module tb_writeback_buffer;
   localparam int DW = 64;
   localparam int AW = 64;
   localparam int LW = DW * 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          evict_valid;
   logic          evict_ready;
   logic [AW-1:0] evict_addr;
   logic [LW-1:0] evict_data;
   logic          command_valid;
   logic          command_store;
   logic          command_rready;
   logic [AW-1:0] command_addr;
   logic [LW-1:0] data_in;
   logic          bus_ready;
   logic [AW-1:0] lookup_addr;
   logic          lookup_hit;
   logic [LW-1:0] lookup_data;
   logic          empty;

   int checks = 0;
   int errors = 0;

   writeback_buffer dut (
      .clk(clk), .reset(reset),
      .evict_valid(evict_valid), .evict_ready(evict_ready),
      .evict_addr(evict_addr), .evict_data(evict_data),
      .command_valid(command_valid), .command_store(command_store),
      .command_rready(command_rready), .command_addr(command_addr),
      .data_in(data_in), .bus_ready(bus_ready),
      .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
      .lookup_data(lookup_data), .empty(empty)
   );

   always #5 clk = ~clk;

   function automatic logic [LW-1:0] pat(input logic [31:0] seed);
      logic [LW-1:0] p;
      for (int i = 0; i < 16; i++) p[i*64 +: 64] = {seed, 32'(i)};
      return p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed beat15=%h beat0=%h expected beat15=%h beat0=%h",
                tag, obs[LW-1 -: 64], obs[63:0], exp[LW-1 -: 64], exp[63:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_line(input logic [AW-1:0] a, input logic [LW-1:0] d);
      evict_valid = 1'b1;
      evict_addr  = a;
      evict_data  = d;
      tick();
      evict_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
      bus_ready = 1'b0; lookup_addr = '0;
      tick(); tick();
      chk("rst_cmd_valid", 64'(command_valid), 64'd0);
      chk("rst_cmd_store", 64'(command_store), 64'd0);
      chk("rst_evict_ready", 64'(evict_ready), 64'd1);
      chk("rst_lookup_hit", 64'(lookup_hit), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_cmd_addr", command_addr, 64'd0);
      chk_line("rst_data_in", data_in, '0);
      reset = 1'b0;
      tick();

      // single line, held while bus stalls
      evict_valid = 1'b1; evict_addr = 64'h1000; evict_data = pat(32'hA);
      #2 chk("t1_no_bypass", 64'(command_valid), 64'd0);
      tick(); evict_valid = 1'b0;
      chk("t1_cmd_valid", 64'(command_valid), 64'd1);
      chk("t1_cmd_store", 64'(command_store), 64'd1);
      chk("t1_rready", 64'(command_rready), 64'd0);
      chk("t1_cmd_addr", command_addr, 64'h1000);
      chk_line("t1_data_in", data_in, pat(32'hA));
      chk("t1_empty", 64'(empty), 64'd0);
      tick();
      chk("t1_held_valid", 64'(command_valid), 64'd1);
      chk_line("t1_held_data", data_in, pat(32'hA));
      bus_ready = 1'b1; tick(); bus_ready = 1'b0;
      chk("t1_popped_valid", 64'(command_valid), 64'd0);
      chk("t1_popped_empty", 64'(empty), 64'd1);

      // fill to full, reject 5th, drain in order
      for (int i = 1; i <= 4; i++) push_line(64'(i * 'h1000), pat(32'(i)));
      chk("t2_full_ready", 64'(evict_ready), 64'd0);
      evict_valid = 1'b1; evict_addr = 64'h5000; evict_data = pat(32'h5);
      tick(); evict_valid = 1'b0;
      bus_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("t2_order%0d", i), command_addr, 64'(i * 'h1000));
         tick();
      end
      bus_ready = 1'b0;
      chk("t2_drained", 64'(empty), 64'd1);

      // full with simultaneous evict and pop: only the pop happens
      for (int i = 1; i <= 4; i++) push_line(64'(i * 'h1000), pat(32'(i)));
      evict_valid = 1'b1; evict_addr = 64'h5000; evict_data = pat(32'hE); bus_ready = 1'b1;
      #1 chk("t3_full_not_ready", 64'(evict_ready), 64'd0);
      tick(); bus_ready = 1'b0;
      chk("t3_after_pop_ready", 64'(evict_ready), 64'd1);
      chk("t3_after_pop_head", command_addr, 64'h2000);
      tick(); evict_valid = 1'b0;
      chk("t3_refull_ready", 64'(evict_ready), 64'd0);
      bus_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         chk($sformatf("t3_order%0d", i), command_addr, 64'(i * 'h1000));
         if (i == 5) chk_line("t3_wrap_data", data_in, pat(32'hE));
         tick();
      end
      bus_ready = 1'b0;
      chk("t3_drained", 64'(empty), 64'd1);

      // lookup
      push_line(64'h2000, pat(32'hB));
      push_line(64'h2080, pat(32'hF));
      lookup_addr = 64'h2008; #1;
      chk("t4_hit_b", 64'(lookup_hit), 64'd1);
      chk_line("t4_data_b", lookup_data, pat(32'hB));
      lookup_addr = 64'h2050; #1;
      chk_line("t4_data_b_hi", lookup_data, pat(32'hB));
      lookup_addr = 64'h2090; #1;
      chk_line("t4_data_f", lookup_data, pat(32'hF));
      lookup_addr = 64'h5000; #1;
      chk("t4_miss", 64'(lookup_hit), 64'd0);
      lookup_addr = 64'h2008; bus_ready = 1'b1; #1;
      chk("t4_pop_cycle_hit", 64'(lookup_hit), 64'd1);
      tick(); bus_ready = 1'b0;
      chk("t4_after_pop_miss", 64'(lookup_hit), 64'd0);
      evict_valid = 1'b1; evict_addr = 64'h7000; evict_data = pat(32'h7);
      lookup_addr = 64'h7000; #1;
      chk("t4_push_invisible", 64'(lookup_hit), 64'd0);
      tick(); evict_valid = 1'b0;
      chk("t4_push_visible", 64'(lookup_hit), 64'd1);
      bus_ready = 1'b1; tick(); tick(); bus_ready = 1'b0;
      chk("t4_drained", 64'(empty), 64'd1);

      // asynchronous reset with entries held
      for (int i = 1; i <= 3; i++) push_line(64'(i * 'h1000), pat(32'(i)));
      chk("t5_pre_valid", 64'(command_valid), 64'd1);
      lookup_addr = 64'h2000;
      #2 reset = 1'b1;
      #1;
      chk("t5_async_valid", 64'(command_valid), 64'd0);
      chk("t5_async_empty", 64'(empty), 64'd1);
      chk("t5_async_ready", 64'(evict_ready), 64'd1);
      chk("t5_async_addr", command_addr, 64'd0);
      chk("t5_async_hit", 64'(lookup_hit), 64'd0);
      tick(); reset = 1'b0; tick();
      chk("t5_no_stale_cmd", 64'(command_valid), 64'd0);
      chk_line("t5_no_stale_data", data_in, '0);

      // repeated eviction of the same line
      push_line(64'h1000, pat(32'hA));
      push_line(64'h3000, pat(32'hC));
      push_line(64'h3000, pat(32'hD));
      lookup_addr = 64'h3000; #1;
      chk_line("t6_lookup_youngest", lookup_data, pat(32'hD));
      bus_ready = 1'b1;
      chk("t6_cmd1_addr", command_addr, 64'h1000);
      tick();
      chk("t6_cmd2_addr", command_addr, 64'h3000);
`ifdef WB_BUFFER_MERGE_EN
      chk_line("t6_cmd2_merged", data_in, pat(32'hD));
      tick();
`else
      chk_line("t6_cmd2_data", data_in, pat(32'hC));
      tick();
      chk("t6_cmd3_addr", command_addr, 64'h3000);
      chk_line("t6_cmd3_data", data_in, pat(32'hD));
      tick();
`endif
      bus_ready = 1'b0;
      chk("t6_drained", 64'(empty), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
